// File: rtl/dfe_chan_sched.sv
// Time-multiplexes NUM_CH antenna channels onto one shared DFE instance.
// A channel switch first injects FLUSH_LEN zero samples; results come back tagged with their owning channel.
module dfe_chan_sched #(
  parameter int NUM_CH    = 4,
  parameter int BURST_LEN = 64,
  parameter int FLUSH_LEN = 16,
  parameter int DFE_LAT   = 1,
  localparam int CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_CH-1:0]    ch_valid,
  output logic [NUM_CH-1:0]    ch_ready,
  input  logic [16*NUM_CH-1:0] ch_data_i,
  input  logic [16*NUM_CH-1:0] ch_data_q,
  output logic [15:0]          adc_data_i,
  output logic [15:0]          adc_data_q,
  output logic                 adc_valid,
  input  logic [31:0]          dfe_out,
  output logic [31:0]          out_data,
  output logic                 out_valid,
  output logic [CW-1:0]        out_ch,
  output logic [CW-1:0]        cur_ch,
  output logic                 busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SELECT = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;
  localparam logic [1:0] ST_STREAM = 2'd3;

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int FW = $clog2(FLUSH_LEN + 1);

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] cur_ch_reg, cur_ch_next;
  logic [CW-1:0] last_ch_reg, last_ch_next;
  logic          last_ch_valid_reg, last_ch_valid_next;
  logic [BW-1:0] burst_cnt_reg, burst_cnt_next;
  logic [FW-1:0] flush_cnt_reg, flush_cnt_next;
  logic [15:0]   data_i_reg, data_q_reg;
  logic          xfer_reg;
  logic [CW-1:0] issue_ch_reg;
  logic [CW:0]   tag_reg [DFE_LAT];

  logic [15:0]   din_i [NUM_CH];
  logic [15:0]   din_q [NUM_CH];
  logic          xfer;
  logic          rr_found;
  logic [CW-1:0] rr_ch;
  logic [CW-1:0] rr_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign din_i[gi]    = ch_data_i[16*gi +: 16];
      assign din_q[gi]    = ch_data_q[16*gi +: 16];
      assign ch_ready[gi] = (state_reg == ST_STREAM) && enable && (cur_ch_reg == CW'(gi));
    end
  endgenerate

  assign xfer = |(ch_valid & ch_ready);

  // Round-robin: scan starting just after the last granted channel, ending on it.
  always_comb begin
    rr_found = 1'b0;
    rr_ch    = '0;
    rr_idx   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      rr_idx = CW'((int'(last_ch_reg) + i) % NUM_CH);
      if (!rr_found && ch_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_ch    = rr_idx;
      end
    end
  end

  always_comb begin
    state_next         = state_reg;
    cur_ch_next        = cur_ch_reg;
    last_ch_next       = last_ch_reg;
    last_ch_valid_next = last_ch_valid_reg;
    burst_cnt_next     = burst_cnt_reg;
    flush_cnt_next     = flush_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (enable && |ch_valid) state_next = ST_SELECT;
      end
      ST_SELECT: begin
        if (rr_found) begin
          cur_ch_next        = rr_ch;
          last_ch_next       = rr_ch;
          last_ch_valid_next = 1'b1;
          if (rr_ch != last_ch_reg || !last_ch_valid_reg) begin
            state_next     = ST_FLUSH;
            flush_cnt_next = '0;
          end else begin
            state_next     = ST_STREAM;
            burst_cnt_next = '0;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_reg == FW'(FLUSH_LEN - 1)) begin
          state_next     = ST_STREAM;
          burst_cnt_next = '0;
        end else begin
          flush_cnt_next = flush_cnt_reg + 1'b1;
        end
      end
      ST_STREAM: begin
        if (xfer) begin
          burst_cnt_next = burst_cnt_reg + 1'b1;
          if (burst_cnt_reg == BW'(BURST_LEN - 1)) state_next = ST_SELECT;
        end else if (!ch_valid[cur_ch_reg] && |ch_valid) begin
          state_next = ST_SELECT;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Dropping enable abandons the channel context, so the next grant re-flushes.
    if (!enable && state_reg != ST_IDLE) begin
      state_next         = ST_IDLE;
      last_ch_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= ST_IDLE;
      cur_ch_reg        <= '0;
      last_ch_reg       <= CW'(NUM_CH - 1);
      last_ch_valid_reg <= 1'b0;
      burst_cnt_reg     <= '0;
      flush_cnt_reg     <= '0;
      data_i_reg        <= '0;
      data_q_reg        <= '0;
      xfer_reg          <= 1'b0;
      issue_ch_reg      <= '0;
      for (int i = 0; i < DFE_LAT; i++) tag_reg[i] <= '0;
    end else begin
      state_reg         <= state_next;
      cur_ch_reg        <= cur_ch_next;
      last_ch_reg       <= last_ch_next;
      last_ch_valid_reg <= last_ch_valid_next;
      burst_cnt_reg     <= burst_cnt_next;
      flush_cnt_reg     <= flush_cnt_next;
      xfer_reg          <= xfer;
      data_i_reg        <= xfer ? din_i[cur_ch_reg] : 16'd0;
      data_q_reg        <= xfer ? din_q[cur_ch_reg] : 16'd0;
      if (xfer) issue_ch_reg <= cur_ch_reg;
      // Tag travels alongside the sample; flush and empty cycles carry live=0.
      tag_reg[0] <= {xfer_reg, issue_ch_reg};
      for (int i = 1; i < DFE_LAT; i++) tag_reg[i] <= tag_reg[i-1];
    end
  end

  assign adc_valid  = (state_reg == ST_FLUSH) | xfer_reg;
  assign adc_data_i = data_i_reg;
  assign adc_data_q = data_q_reg;
  assign out_valid  = tag_reg[DFE_LAT-1][CW];
  assign out_ch     = tag_reg[DFE_LAT-1][CW-1:0];
  assign out_data   = dfe_out;
  assign cur_ch     = cur_ch_reg;
  assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_dfe_chan_sched.sv
// Directed bench for dfe_chan_sched: hand-computed grant/flush/burst expectations plus
// a scoreboard matching every transfer to its tagged DFE result.
module tb_dfe_chan_sched;
  localparam logic [31:0] MASK = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  ch_valid = 4'b0;
  logic [3:0]  ch_ready;
  logic [63:0] ch_data_i, ch_data_q;
  logic [15:0] adc_data_i, adc_data_q;
  logic        adc_valid;
  logic [31:0] dfe_out = 32'd0;
  logic [31:0] out_data;
  logic        out_valid;
  logic [1:0]  out_ch, cur_ch;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb_q[$];

  dfe_chan_sched dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_data_i(ch_data_i), .ch_data_q(ch_data_q),
    .adc_data_i(adc_data_i), .adc_data_q(adc_data_q), .adc_valid(adc_valid),
    .dfe_out(dfe_out), .out_data(out_data), .out_valid(out_valid),
    .out_ch(out_ch), .cur_ch(cur_ch), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sample data encodes channel and cycle; Q is the complement so a real sample is never all-zero.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ch_data_i[16*k +: 16] = {4'(k), 12'(cyc)};
      ch_data_q[16*k +: 16] = ~{4'(k), 12'(cyc)};
    end
  end

  // One-cycle DFE model.
  always @(posedge clk) dfe_out <= {adc_data_i, adc_data_q} ^ MASK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: push on every handshake, pop and compare on every out_valid.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      chk("ready_onehot", 32'($onehot0(ch_ready)), 32'd1);
      for (int k = 0; k < 4; k++) begin
        if (ch_valid[k] && ch_ready[k]) begin
          e.ch   = 2'(k);
          e.data = {ch_data_i[16*k +: 16], ch_data_q[16*k +: 16]} ^ MASK;
          e.due  = cyc + 2;
          sb_q.push_back(e);
        end
      end
      if (out_valid) begin
        chk("sb_expected_present", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("sb_out_ch", 32'(out_ch), 32'(e.ch));
          chk("sb_out_data", out_data, e.data);
          chk("sb_latency", cyc, e.due);
          $display("out ch=%0d data=%08h cycle=%0d", out_ch, out_data, cyc);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; enable = 1'b0; ch_valid = 4'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    @(posedge clk); #1;
    ch_valid = 4'b0; enable = 1'b0;
    repeat (6) @(negedge clk);
    chk(name, 32'(sb_q.size()), 32'd0);
  endtask

  // Waits for the next grant, counting zero-sample flush cycles, then counts transfers
  // until ready drops. Valid is held by the caller throughout.
  task automatic measure_turn(output int gap, output int flushes, output int xfers, output int granted);
    gap = 0; flushes = 0; xfers = 0; granted = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ch_ready != 4'b0) break;
      gap++;
      if (adc_valid && adc_data_i == 16'd0 && adc_data_q == 16'd0) flushes++;
    end
    chk("grant_seen", 32'(ch_ready != 4'b0), 32'd1);
    if (ch_ready == 4'b0) return;
    for (int k = 0; k < 4; k++) if (ch_ready[k]) granted = k;
    for (int n = 0; n < 300; n++) begin
      if (ch_ready != (4'b1 << granted)) break;
      if (ch_valid[granted]) xfers++;
      @(negedge clk);
    end
    $display("turn ch=%0d gap=%0d flushes=%0d xfers=%0d", granted, gap, flushes, xfers);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap, fl, xf, gr, cnt;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ch_ready), 32'd0);
    chk("rst_adc_valid", 32'(adc_valid), 32'd0);
    chk("rst_adc_i", 32'(adc_data_i), 32'd0);
    chk("rst_adc_q", 32'(adc_data_q), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_cur_ch", 32'(cur_ch), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    $display("reset checks done");
    @(posedge clk); #1 rst_n = 1'b1;

    // Single channel 0: IDLE, SELECT, 16 flushes, then stream.
    @(posedge clk); #1;
    enable = 1'b1; ch_valid = 4'b0001;
    @(negedge clk);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t1_select_busy", 32'(busy), 32'd1);
    chk("t1_select_ready", 32'(ch_ready), 32'd0);
    chk("t1_select_adc_valid", 32'(adc_valid), 32'd0);
    measure_turn(gap, fl, xf, gr);
    chk("t1_gap", gap, 32'd16);
    chk("t1_flushes", fl, 32'd16);
    chk("t1_grant", gr, 32'd0);
    chk("t1_xfers", xf, 32'd64);
    drain("t1_drain");

    // All four channels: 0,1,2,3,0 with 16 flushes and 64 transfers per turn.
    do_reset();
    @(posedge clk); #1;
    enable = 1'b1; ch_valid = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      measure_turn(gap, fl, xf, gr);
      chk($sformatf("t2_grant%0d", t), gr, exp_order[t]);
      chk($sformatf("t2_flushes%0d", t), fl, 32'd16);
      chk($sformatf("t2_xfers%0d", t), xf, 32'd64);
    end
    drain("t2_drain");

    // Only channel 2: the regrant after a full burst skips the flush.
    do_reset();
    @(posedge clk); #1;
    enable = 1'b1; ch_valid = 4'b0100;
    measure_turn(gap, fl, xf, gr);
    chk("t3_grant_a", gr, 32'd2);
    chk("t3_flushes_a", fl, 32'd16);
    chk("t3_xfers_a", xf, 32'd64);
    measure_turn(gap, fl, xf, gr);
    chk("t3_grant_b", gr, 32'd2);
    chk("t3_gap_b", gap, 32'd0);
    chk("t3_flushes_b", fl, 32'd0);
    chk("t3_xfers_b", xf, 32'd64);
    drain("t3_drain");

    // Early release: channel 1 stops after 10 transfers, channel 3 takes over after a flush.
    do_reset();
    @(posedge clk); #1;
    enable = 1'b1; ch_valid = 4'b0010;
    cnt = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ch_valid[1] && ch_ready[1]) cnt++;
      if (cnt == 10) break;
    end
    chk("t4_ten_xfers", cnt, 32'd10);
    @(posedge clk); #1 ch_valid = 4'b1000;
    @(negedge clk);
    chk("t4_still_stream", 32'(ch_ready), 32'b0010);
    @(negedge clk);
    chk("t4_select_ready", 32'(ch_ready), 32'd0);
    chk("t4_select_cur", 32'(cur_ch), 32'd1);
    chk("t4_select_busy", 32'(busy), 32'd1);
    measure_turn(gap, fl, xf, gr);
    chk("t4_grant", gr, 32'd3);
    chk("t4_flushes", fl, 32'd16);
    chk("t4_xfers", xf, 32'd64);
    drain("t4_drain");

    // Abort flush at count 5, re-enable: a full flush again.
    do_reset();
    @(posedge clk); #1;
    enable = 1'b1; ch_valid = 4'b0001;
    cnt = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (adc_valid && adc_data_i == 16'd0 && adc_data_q == 16'd0 && ch_ready == 4'b0) cnt++;
      if (cnt == 5) break;
    end
    chk("t5_five_flushes", cnt, 32'd5);
    @(posedge clk); #1 enable = 1'b0;
    @(negedge clk);
    chk("t5_abort_cycle_busy", 32'(busy), 32'd1);
    chk("t5_abort_cycle_adc", 32'(adc_valid), 32'd1);
    @(negedge clk);
    chk("t5_idle_busy", 32'(busy), 32'd0);
    chk("t5_idle_adc", 32'(adc_valid), 32'd0);
    @(posedge clk); #1 enable = 1'b1;
    measure_turn(gap, fl, xf, gr);
    chk("t5_grant", gr, 32'd0);
    chk("t5_reflush", fl, 32'd16);
    drain("t5_drain");

    // Asynchronous reset mid-STREAM on channel 2, then fresh flushed grant to channel 0.
    do_reset();
    @(posedge clk); #1;
    enable = 1'b1; ch_valid = 4'b0100;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ch_ready == 4'b0100) break;
    end
    chk("t6_streaming", 32'(ch_ready), 32'b0100);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0; ch_valid = 4'b1111;
    #1;
    chk("t6_async_ready", 32'(ch_ready), 32'd0);
    chk("t6_async_adc_valid", 32'(adc_valid), 32'd0);
    chk("t6_async_adc_i", 32'(adc_data_i), 32'd0);
    chk("t6_async_out_valid", 32'(out_valid), 32'd0);
    chk("t6_async_out_ch", 32'(out_ch), 32'd0);
    chk("t6_async_cur_ch", 32'(cur_ch), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    measure_turn(gap, fl, xf, gr);
    chk("t6_grant", gr, 32'd0);
    chk("t6_flushes", fl, 32'd16);
    drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dfe_chan_sched.md
DFE_CHAN_SCHED -- requirements
Module: dfe_chan_sched

Interface
- REQ-001: Parameter NUM_CH, default 4: number of antenna channels sharing one digital_front_end instance.
- REQ-002: Parameter BURST_LEN, default 64: maximum samples granted to one channel per turn.
- REQ-003: Parameter FLUSH_LEN, default 16: zero samples injected on a channel switch, matching the DFE delay-line depth.
- REQ-004: Parameter DFE_LAT, default 1: cycles from adc_valid into the DFE to the corresponding dfe_out.
- REQ-005: Ports:
  - clk  in  1  single clock; all logic on its rising edge.
  - rst_n  in  1  asynchronous, active-low reset.
  - enable  in  1  scheduler enable.
  - ch_valid  in  NUM_CH  per-channel sample request.
  - ch_ready  out  NUM_CH  per-channel accept.
  - ch_data_i  in  16*NUM_CH  I samples; channel k occupies bits [16k+15:16k].
  - ch_data_q  in  16*NUM_CH  Q samples; same packing as ch_data_i.
  - adc_data_i  out  16  I sample to the DFE.
  - adc_data_q  out  16  Q sample to the DFE.
  - adc_valid  out  1  sample strobe to the DFE.
  - dfe_out  in  32  DFE result.
  - out_data  out  32  tagged result.
  - out_valid  out  1  out_data valid.
  - out_ch  out  clog2(NUM_CH)  channel owning out_data.
  - cur_ch  out  clog2(NUM_CH)  currently granted channel.
  - busy  out  1  high whenever state is not IDLE.

Function
- REQ-006: FSM states: IDLE, SELECT, FLUSH, STREAM.
- REQ-007: IDLE -> SELECT when enable=1 and any ch_valid bit is 1; otherwise stay in IDLE.
- REQ-008: SELECT lasts exactly one cycle and applies round-robin.
  - Search order is last_ch+1, last_ch+2, ... with wrap, ending at last_ch.
  - Grant the first requesting channel found.
  - If no channel is requesting, go to IDLE.
- REQ-009: From SELECT, go to FLUSH if the granted channel differs from last_ch or last_ch_valid=0; otherwise go to STREAM. In both cases update cur_ch, last_ch and last_ch_valid.
- REQ-010: In FLUSH, drive adc_valid=1 with adc_data_i=adc_data_q=0 for exactly FLUSH_LEN consecutive cycles, then enter STREAM. ch_ready stays all-zero during FLUSH.
- REQ-011: ch_ready[k] is combinational: 1 only when state=STREAM, enable=1 and cur_ch=k; all other ready bits are 0.
- REQ-012: A transfer is ch_valid[cur_ch] & ch_ready[cur_ch]. Its data appears on adc_data_i/q, with adc_valid=1, on the next cycle.
  - adc_valid=0 in any cycle that carries neither a transfer nor a flush sample.
- REQ-013: The burst counter clears on entry to STREAM and increments on each transfer.
  - When the counter reaches BURST_LEN, go to SELECT.
  - The BURST_LEN-th transfer completes in that same cycle.
- REQ-014: Early release: in STREAM, if ch_valid[cur_ch]=0 and any other channel is requesting, go to SELECT. If no channel is requesting, stay in STREAM.
- REQ-015: If enable=0 in any non-IDLE state, go to IDLE on the next edge and clear last_ch_valid. This aborts FLUSH, and the next grant flushes again.
- REQ-016: Every issued sample pushes a tag {live, ch} into a DFE_LAT-deep shift register; live=0 for flush samples, live=1 for transfers. Cycles without adc_valid push live=0.
- REQ-017: Output tagging:
  - out_valid equals the tag's live bit emerging after DFE_LAT cycles.
  - out_ch equals the tag's ch field.
  - out_data equals dfe_out, passed through combinationally.
  - Flush results are never presented.
- REQ-018: The scheduler ignores the DFE's own dfe_valid.
- REQ-019: Transfer-to-out_valid latency is 1+DFE_LAT cycles. There is no backpressure on out_data.
- REQ-020: At most one channel is granted at any time; ch_ready is one-hot or zero.

Reset
- REQ-021: rst_n=0 asynchronously forces:
  - state=IDLE;
  - ch_ready=0, adc_valid=0, adc_data_i=adc_data_q=0;
  - out_valid=0, out_ch=0, cur_ch=0, busy=0;
  - burst and flush counters=0;
  - tag pipeline cleared (all live=0);
  - last_ch=NUM_CH-1, last_ch_valid=0.
- REQ-022: Reset mid-operation discards in-flight tags. The first grant after reset always flushes.

Verification
- REQ-023: Reset, then enable=1 with ch_valid=0001 held -> SELECT, then 16 flush cycles (adc_valid=1, data 0, out_valid=0), then ch_ready=0001. The first out_valid occurs 2 cycles after the first transfer, with out_ch=0.
- REQ-024: All four channels valid continuously -> grant order 0,1,2,3,0. Each turn gives exactly 64 transfers and is preceded by 16 flush samples. ch_ready is never multi-hot.
- REQ-025: Only channel 2 valid, BURST_LEN reached -> SELECT regrants channel 2 without FLUSH. STREAM resumes 2 cycles after the last transfer.
- REQ-026: Channel 1 drops valid after 10 transfers while channel 3 requests -> SELECT next cycle, channel 3 is granted, 16 flushes are injected, and out_ch switches 1->3 with no live outputs in between.
- REQ-027: enable=0 at flush count 5 -> IDLE next cycle. Re-enable on the same channel -> a full 16-sample flush is repeated.
- REQ-028: rst_n asserted mid-STREAM -> all outputs 0 immediately, asynchronously before the next clock edge. The first post-reset grant goes to channel 0 if requesting and is flushed.
